// File: rtl/mux_n_registrado_pkg.sv
// Shared definitions for the registered N-channel multiplexer.
// Operating modes and the round-robin index helper.
package mux_n_registrado_pkg;

    typedef enum logic {
        MODO_FIXO = 1'b0,
        MODO_RR   = 1'b1
    } modo_t;

    // Next channel after `canal`, wrapping at `canais`.
    function automatic int unsigned prox_canal(input int unsigned canal,
                                               input int unsigned canais);
        return (canal + 1 >= canais) ? 0 : canal + 1;
    endfunction

endpackage

// File: rtl/mux_n_registrado_if.sv
// Source/sink bus of the registered multiplexer: channel data and requests in,
// grants and registered result (valid/ready) out.
interface mux_n_registrado_if #(
    parameter int unsigned CANAIS  = 4,
    parameter int unsigned LARGURA = 8
);
    localparam int unsigned SEL_W = $clog2(CANAIS);

    logic [CANAIS*LARGURA-1:0] Entradas;
    logic [CANAIS-1:0]         Requisicao;
    logic [CANAIS-1:0]         Concedido;
    logic                      Modo;
    logic [SEL_W-1:0]          Controle;
    logic [LARGURA-1:0]        Resultado;
    logic                      ResultadoValido;
    logic [SEL_W-1:0]          CanalAtual;
    logic                      Pronto;

    modport master (
        output Entradas, Requisicao, Modo, Controle, Pronto,
        input  Concedido, Resultado, ResultadoValido, CanalAtual
    );

    modport slave (
        input  Entradas, Requisicao, Modo, Controle, Pronto,
        output Concedido, Resultado, ResultadoValido, CanalAtual
    );

endinterface

// File: rtl/mux_n_registrado_arbitro_rr.sv
// Combinational round-robin arbiter: first requesting channel at or after
// the pointer, wrapping modulo CANAIS.
module arbitro_rr #(
    parameter int unsigned CANAIS = 4,
    parameter int unsigned SEL_W  = $clog2(CANAIS)
) (
    input  logic [CANAIS-1:0] requisicao,
    input  logic [SEL_W-1:0]  ponteiro,
    output logic [CANAIS-1:0] concessao,
    output logic [SEL_W-1:0]  vencedor,
    output logic              encontrado
);

    int unsigned idx;

    always_comb begin
        concessao  = '0;
        vencedor   = '0;
        encontrado = 1'b0;
        idx        = 0;
        for (int unsigned k = 0; k < CANAIS; k++) begin
            idx = 32'(ponteiro) + k;
            if (idx >= CANAIS) begin
                idx = idx - CANAIS;
            end
            if (!encontrado && requisicao[idx[SEL_W-1:0]]) begin
                encontrado                  = 1'b1;
                vencedor                    = idx[SEL_W-1:0];
                concessao[idx[SEL_W-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_n_registrado.sv
// N-channel W-bit multiplexer with registered output and valid/ready handshake;
// fixed-select or round-robin source selection.
module mux_n_registrado
    import mux_n_registrado_pkg::*;
#(
    parameter int unsigned CANAIS  = 4,
    parameter int unsigned LARGURA = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    mux_n_registrado_if.slave  bus
);

    localparam int unsigned SEL_W = $clog2(CANAIS);

    modo_t               modo;
    logic [SEL_W-1:0]    ponteiro;
    logic [LARGURA-1:0]  resultado;
    logic                valido;
    logic [SEL_W-1:0]    canal;

    logic                carga;
    logic                captura;
    logic                fixo_ok;
    logic [SEL_W-1:0]    sel;
    logic [CANAIS-1:0]   concedido;
    logic [LARGURA-1:0]  dado;

    logic [CANAIS-1:0]   rr_concessao;
    logic [SEL_W-1:0]    rr_vencedor;
    logic                rr_encontrado;

    assign modo = modo_t'(bus.Modo);

    arbitro_rr #(
        .CANAIS (CANAIS),
        .SEL_W  (SEL_W)
    ) u_arbitro (
        .requisicao (bus.Requisicao),
        .ponteiro   (ponteiro),
        .concessao  (rr_concessao),
        .vencedor   (rr_vencedor),
        .encontrado (rr_encontrado)
    );

    // Controle may exceed CANAIS-1 when CANAIS is not a power of two.
    assign fixo_ok = (32'(bus.Controle) < CANAIS) && bus.Requisicao[bus.Controle];

    always_comb begin
        carga     = !valido || bus.Pronto;
        captura   = 1'b0;
        sel       = '0;
        concedido = '0;
        if (Reset && carga) begin
            if (modo == MODO_RR) begin
                if (rr_encontrado) begin
                    captura   = 1'b1;
                    sel       = rr_vencedor;
                    concedido = rr_concessao;
                end
            end else if (fixo_ok) begin
                captura             = 1'b1;
                sel                 = bus.Controle;
                concedido[bus.Controle] = 1'b1;
            end
        end
    end

    assign dado = bus.Entradas[32'(sel)*LARGURA +: LARGURA];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            resultado <= '0;
            valido    <= 1'b0;
            canal     <= '0;
            ponteiro  <= '0;
        end else if (carga) begin
            valido <= captura;
            if (captura) begin
                resultado <= dado;
                canal     <= sel;
            end
            if (captura && modo == MODO_RR) begin
                ponteiro <= SEL_W'(prox_canal(32'(rr_vencedor), CANAIS));
            end
        end
    end

    assign bus.Concedido       = concedido;
    assign bus.Resultado       = resultado;
    assign bus.ResultadoValido = valido;
    assign bus.CanalAtual      = canal;

    grant_onehot: assert property (@(posedge Clock) disable iff (!Reset)
        $onehot0(concedido));

    hold_on_stall: assert property (@(posedge Clock) disable iff (!Reset)
        (valido && !bus.Pronto) |=> ($stable(resultado) && $stable(canal) && valido));

endmodule

// File: tb/tb_mux_n_registrado.sv
// Scoreboard bench for mux_n_registrado: directed scenarios plus random traffic
// checked against a queue-based transfer model.
module tb_mux_n_registrado;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_n_registrado_if #(.CANAIS(N), .LARGURA(W)) bus ();

    mux_n_registrado #(.CANAIS(N), .LARGURA(W)) dut (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] dado;
        int unsigned  canal;
    } item_t;

    item_t       q[$];
    item_t       staged;
    bit          staged_v = 1'b0;
    int unsigned rr_ptr   = 0;
    logic [W-1:0] chan_data[N];

    int checks   = 0;
    int failures = 0;

    function automatic void check(input string nome, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nome, act, exp, $time);
        end
    endfunction

    task automatic drive(input bit m, input int unsigned c, input logic [N-1:0] r, input bit p);
        logic [31:0] cw;
        cw = c;
        bus.Modo       = m;
        bus.Controle   = cw[1:0];
        bus.Requisicao = r;
        bus.Pronto     = p;
        for (int i = 0; i < N; i++) bus.Entradas[i*W +: W] = chan_data[i];
    endtask

    // One clock cycle of stimulus; the model decides the grant from the spec rules.
    task automatic ciclo(input bit m, input int unsigned c, input logic [N-1:0] r, input bit p);
        int          win;
        logic [N-1:0] exp_g;
        @(posedge clk);
        #1;
        if (staged_v) begin
            q.push_back(staged);
            staged_v = 1'b0;
        end
        drive(m, c, r, p);
        #2;
        exp_g = '0;
        win   = -1;
        if (q.size() == 0 || p) begin
            if (!m) begin
                if (c < N && r[c]) win = int'(c);
            end else begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (int'(rr_ptr) + k) % N;
                    if (win < 0 && r[j]) win = j;
                end
            end
            if (win >= 0) begin
                exp_g[win] = 1'b1;
                staged     = '{dado: chan_data[win], canal: win};
                staged_v   = 1'b1;
                if (m) rr_ptr = (win + 1) % N;
            end
        end
        check("concedido", 32'(bus.Concedido), 32'(exp_g));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_resultado"}, 32'(bus.Resultado), 32'h0);
        check({tag, "_valido"},    32'(bus.ResultadoValido), 32'h0);
        check({tag, "_canal"},     32'(bus.CanalAtual), 32'h0);
        check({tag, "_concedido"}, 32'(bus.Concedido), 32'h0);
    endtask

    task automatic ciclo_rand_em_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) chan_data[i] = W'($urandom);
        drive(1'($urandom), $urandom_range(0, N-1), N'($urandom), 1'($urandom));
        #2;
        check_reset_outputs("reset");
    endtask

    // Monitor: compares whatever the DUT presents against the head of the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            bit exp_v;
            exp_v = (q.size() != 0);
            check("valido", 32'(bus.ResultadoValido), 32'(exp_v));
            if (exp_v) begin
                if (bus.ResultadoValido) begin
                    check("resultado", 32'(bus.Resultado), 32'(q[0].dado));
                    check("canal_atual", 32'(bus.CanalAtual), q[0].canal);
                end
                if (bus.Pronto) void'(q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        chan_data[0] = 8'hA0;
        chan_data[1] = 8'hB1;
        chan_data[2] = 8'hC2;
        chan_data[3] = 8'hD3;
        drive(1'b0, 0, '0, 1'b1);

        // Reset held with random inputs, then release with no requests.
        repeat (3) ciclo_rand_em_reset();
        @(posedge clk);
        #1;
        chan_data[0] = 8'hA0;
        chan_data[1] = 8'hB1;
        chan_data[2] = 8'hC2;
        chan_data[3] = 8'hD3;
        drive(1'b0, 0, '0, 1'b1);
        rst_n = 1'b1;
        repeat (3) begin
            ciclo(1'b0, 0, '0, 1'b1);
            check("pos_reset_resultado", 32'(bus.Resultado), 32'h0);
            check("pos_reset_canal", 32'(bus.CanalAtual), 32'h0);
        end

        // Fixed select: granted channel, then a non-requesting select.
        ciclo(1'b0, 2, 4'b0100, 1'b1);
        ciclo(1'b0, 1, 4'b0100, 1'b1);
        ciclo(1'b0, 0, 4'b0000, 1'b1);

        // Round-robin with all channels requesting.
        repeat (5) ciclo(1'b1, 0, 4'b1111, 1'b1);
        ciclo(1'b1, 0, 4'b0000, 1'b1);

        // Back-pressure, setting changes while held, then resume.
        ciclo(1'b1, 0, 4'b1010, 1'b1);
        repeat (2) ciclo(1'b1, 0, 4'b1010, 1'b0);
        ciclo(1'b0, 3, 4'b1010, 1'b0);
        ciclo(1'b1, 0, 4'b1010, 1'b1);
        ciclo(1'b1, 0, 4'b0000, 1'b1);

        // Random traffic.
        repeat (300) begin
            for (int i = 0; i < N; i++) chan_data[i] = W'($urandom);
            ciclo(1'($urandom), $urandom_range(0, N-1), N'($urandom),
                  ($urandom_range(0, 3) != 0));
        end
        chan_data[0] = 8'hA0;
        chan_data[1] = 8'hB1;
        chan_data[2] = 8'hC2;
        chan_data[3] = 8'hD3;
        repeat (2) ciclo(1'b0, 0, '0, 1'b1);

        // Reset asserted mid-stream.
        repeat (3) ciclo(1'b1, 0, 4'b1111, 1'b1);
        @(posedge clk);
        #1;
        if (staged_v) begin
            q.push_back(staged);
            staged_v = 1'b0;
        end
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_meio");
        q.delete();
        rr_ptr = 0;
        repeat (2) ciclo_rand_em_reset();
        @(posedge clk);
        #1;
        chan_data[0] = 8'hA0;
        chan_data[1] = 8'hB1;
        chan_data[2] = 8'hC2;
        chan_data[3] = 8'hD3;
        drive(1'b1, 0, '0, 1'b1);
        rst_n = 1'b1;
        repeat (2) ciclo(1'b1, 0, 4'b1111, 1'b1);
        repeat (3) ciclo(1'b1, 0, 4'b0000, 1'b1);

        @(posedge clk);
        #1;
        check("fila_vazia", 32'(q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
